// File: rtl/udp_recv_checker.sv
// UDP receive payload checker: compares every payload byte against an incrementing
// pattern, judges packet length, and keeps good/bad packet statistics.
module udp_recv_checker #(
  parameter int P_EXP_LEN = 100,
  parameter int P_PKT_NUM = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_recv_udp_data,
  input  logic [15:0] i_recv_udp_len,
  input  logic        i_recv_udp_last,
  input  logic        i_recv_udp_valid,
  input  logic        i_clr,
  output logic        o_pkt_done,
  output logic        o_pkt_ok,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_bad_cnt,
  output logic [15:0] o_first_err_idx,
  output logic        o_all_done,
  output logic        o_busy
);

  localparam logic [15:0] LP_EXP_LEN = 16'(P_EXP_LEN);
  localparam logic [16:0] LP_PKT_NUM = 17'(P_PKT_NUM);
  localparam logic [15:0] LP_NO_ERR  = 16'hFFFF;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d, len_q, len_d, err_idx_q, err_idx_d;
  logic        err_q, err_d;
  logic        pkt_done_q, pkt_done_d, pkt_ok_q, pkt_ok_d;
  logic        all_done_q, all_done_d, busy_q, busy_d;
  logic [15:0] good_q, good_d, bad_q, bad_d, first_err_q, first_err_d;

  logic        judge_s, trunc_s, ok_s, fin_err_s, mism_s, cur_err_s;
  logic [15:0] fin_idx_s, fin_cnt_s, fin_len_s, beat_inc_s, cur_idx_s;
  logic [16:0] total_s;

  // Packet FSM: beat tracking, first-mismatch capture and judgement strobe
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    judge_s    = 1'b0;
    trunc_s    = 1'b0;
    fin_err_s  = 1'b0;
    fin_idx_s  = LP_NO_ERR;
    fin_cnt_s  = 16'd0;
    fin_len_s  = len_q;
    beat_inc_s = (beat_q == 16'hFFFF) ? 16'hFFFF : beat_q + 16'd1;
    mism_s     = (i_recv_udp_data != ((state_q == S_RECV) ? beat_q[7:0] : 8'h00));
    cur_err_s  = err_q | mism_s;
    cur_idx_s  = err_q ? err_idx_q : (mism_s ? beat_q : LP_NO_ERR);
    case (state_q)
      S_IDLE: begin
        if (i_recv_udp_valid) begin
          if (i_recv_udp_last) begin
            judge_s   = 1'b1;
            fin_cnt_s = 16'd1;
            fin_len_s = i_recv_udp_len;
            fin_err_s = mism_s;
            fin_idx_s = mism_s ? 16'd0 : LP_NO_ERR;
          end else begin
            state_d   = S_RECV;
            beat_d    = 16'd1;
            len_d     = i_recv_udp_len;
            err_d     = mism_s;
            err_idx_d = mism_s ? 16'd0 : LP_NO_ERR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (i_recv_udp_valid) begin
          if (i_recv_udp_last) begin
            judge_s   = 1'b1;
            fin_cnt_s = beat_inc_s;
            fin_err_s = cur_err_s;
            fin_idx_s = cur_idx_s;
            state_d   = S_IDLE;
            beat_d    = 16'd0;
            err_d     = 1'b0;
            err_idx_d = LP_NO_ERR;
          end else begin
            beat_d    = beat_inc_s;
            err_d     = cur_err_s;
            err_idx_d = cur_idx_s;
          end
        end else begin
          // A gap inside a packet means the stack truncated it
          judge_s   = 1'b1;
          trunc_s   = 1'b1;
          state_d   = S_IDLE;
          beat_d    = 16'd0;
          err_d     = 1'b0;
          err_idx_d = LP_NO_ERR;
        end
      end
      default: begin
        state_d   = S_IDLE;
        beat_d    = 16'd0;
        err_d     = 1'b0;
        err_idx_d = LP_NO_ERR;
      end
    endcase
    ok_s = judge_s & ~trunc_s & ~fin_err_s & (fin_cnt_s == fin_len_s) &
           (fin_len_s == LP_EXP_LEN) & (fin_cnt_s != 16'hFFFF);
  end

  // Judgement result, saturating statistics and status flags
  always_comb begin
    pkt_done_d  = judge_s;
    pkt_ok_d    = pkt_ok_q;
    good_d      = good_q;
    bad_d       = bad_q;
    first_err_d = first_err_q;
    if (judge_s) begin
      pkt_ok_d = ok_s;
      if (ok_s) begin
        good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
      end else begin
        bad_d = (bad_q == 16'hFFFF) ? bad_q : bad_q + 16'd1;
        if (!trunc_s) begin
          first_err_d = fin_idx_s;
        end else begin
          first_err_d = first_err_q;
        end
      end
    end else begin
      pkt_ok_d = pkt_ok_q;
    end
    total_s    = {1'b0, good_d} + {1'b0, bad_d};
    all_done_d = (total_s >= LP_PKT_NUM);
    busy_d     = (state_d == S_RECV);
  end

  // State and output registers; i_clr acts as a synchronous clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      beat_q      <= 16'd0;
      len_q       <= 16'd0;
      err_q       <= 1'b0;
      err_idx_q   <= LP_NO_ERR;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      good_q      <= 16'd0;
      bad_q       <= 16'd0;
      first_err_q <= LP_NO_ERR;
      all_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (i_clr) begin
      state_q     <= S_IDLE;
      beat_q      <= 16'd0;
      len_q       <= 16'd0;
      err_q       <= 1'b0;
      err_idx_q   <= LP_NO_ERR;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      good_q      <= 16'd0;
      bad_q       <= 16'd0;
      first_err_q <= LP_NO_ERR;
      all_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      first_err_q <= first_err_d;
      all_done_q  <= all_done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_pkt_done      = pkt_done_q;
  assign o_pkt_ok        = pkt_ok_q;
  assign o_good_cnt      = good_q;
  assign o_bad_cnt       = bad_q;
  assign o_first_err_idx = first_err_q;
  assign o_all_done      = all_done_q;
  assign o_busy          = busy_q;

endmodule
